// File: rtl/game_round_ctrl_pkg.sv
// Shared types and result codes for the Tom & Jerry round sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    OVER_HOLD = 2'd2,
    OVER_WAIT = 2'd3
  } round_state_t;

  localparam logic [1:0] GO_NONE  = 2'b00;
  localparam logic [1:0] GO_TOM   = 2'b01;
  localparam logic [1:0] GO_JERRY = 2'b10;

endpackage

// File: rtl/game_round_ctrl_edge_rise.sv
// One-bit rising-edge detector; the pulse is combinational and one clk wide.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Previous-sample register for the edge compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: idle / playing / game-over hold / game-over wait, round timer
// and winner decision, all outputs registered.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int ROUND_SEC   = 60,
  parameter int FPS         = 60,
  parameter int HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start,
  input  logic       caught,
  input  logic       all_cheese,
  output logic [1:0] gameover,
  output logic       playing,
  output logic       freeze,
  output logic       world_rst,
  output logic [7:0] sec_left
);

  localparam int FC_W = (FPS > 1) ? $clog2(FPS) : 1;
  localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FPS - 1);
  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(HOLD_FRAMES - 1);
  localparam logic [7:0]      SEC_INIT = 8'(ROUND_SEC);

  logic frame_tick;
  logic start_rise;

  edge_rise u_vblnk_rise (.clk(clk), .rst_n(rst), .d(vblnk), .rise(frame_tick));
  edge_rise u_start_rise (.clk(clk), .rst_n(rst), .d(start), .rise(start_rise));

  round_state_t    state_q,     state_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [HC_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [7:0]      sec_left_q,  sec_left_d;
  logic [1:0]      gameover_q,  gameover_d;
  logic            playing_q,   playing_d;
  logic            freeze_q,    freeze_d;
  logic            world_rst_q, world_rst_d;
  logic            enter_play;

  // Next-state, counter and output computation.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    sec_left_d  = sec_left_q;
    gameover_d  = gameover_q;
    world_rst_d = 1'b0;
    enter_play  = 1'b0;

    case (state_q)
      IDLE:      enter_play = start_rise;
      PLAYING: begin
        // caught outranks all_cheese, which outranks the timeout
        if (caught) begin
          gameover_d = GO_TOM;
          state_d    = OVER_HOLD;
          hold_cnt_d = '0;
        end else if (all_cheese) begin
          gameover_d = GO_JERRY;
          state_d    = OVER_HOLD;
          hold_cnt_d = '0;
        end else if (frame_tick) begin
          if (sec_left_q == 8'd0) begin
            gameover_d = GO_JERRY;
            state_d    = OVER_HOLD;
            hold_cnt_d = '0;
          end else if (frame_cnt_q == FC_LAST) begin
            frame_cnt_d = '0;
            sec_left_d  = sec_left_q - 8'd1;
          end else begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
          end
        end else begin
          state_d = PLAYING;
        end
      end
      OVER_HOLD: begin
        if (frame_tick) begin
          if (hold_cnt_q == HC_LAST) begin
            state_d = OVER_WAIT;
          end else begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      OVER_WAIT: enter_play = start_rise;
      default:   state_d = IDLE;
    endcase

    if (enter_play) begin
      state_d     = PLAYING;
      frame_cnt_d = '0;
      sec_left_d  = SEC_INIT;
      gameover_d  = GO_NONE;
      world_rst_d = 1'b1;
    end else begin
      world_rst_d = 1'b0;
    end

    playing_d = (state_d == PLAYING);
    freeze_d  = ~playing_d;
  end

  // State, counters and registered Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      hold_cnt_q  <= '0;
      sec_left_q  <= SEC_INIT;
      gameover_q  <= GO_NONE;
      playing_q   <= 1'b0;
      freeze_q    <= 1'b1;
      world_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      sec_left_q  <= sec_left_d;
      gameover_q  <= gameover_d;
      playing_q   <= playing_d;
      freeze_q    <= freeze_d;
      world_rst_q <= world_rst_d;
    end
  end

  assign gameover  = gameover_q;
  assign playing   = playing_q;
  assign freeze    = freeze_q;
  assign world_rst = world_rst_q;
  assign sec_left  = sec_left_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: directed scenarios then random play,
// checked against a frame-counting reference model.
module tb_game_round_ctrl;

  localparam int ROUND_SEC   = 3;
  localparam int FPS         = 4;
  localparam int HOLD_FRAMES = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vblnk = 1'b0;
  logic       start = 1'b0;
  logic       caught = 1'b0;
  logic       all_cheese = 1'b0;
  logic [1:0] gameover;
  logic       playing;
  logic       freeze;
  logic       world_rst;
  logic [7:0] sec_left;

  game_round_ctrl #(
    .ROUND_SEC(ROUND_SEC), .FPS(FPS), .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start(start), .caught(caught),
    .all_cheese(all_cheese), .gameover(gameover), .playing(playing),
    .freeze(freeze), .world_rst(world_rst), .sec_left(sec_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] go;
    logic       playing;
    logic       freeze;
    logic       wrst;
    logic [7:0] sec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a round is just a count of frames played so far.
  bit m_in_round;
  int m_frames;
  int m_result;
  int m_hold;
  bit m_wrst;
  bit m_pv;
  bit m_ps;

  function automatic void model_reset();
    m_in_round = 1'b0;
    m_frames   = 0;
    m_result   = 0;
    m_hold     = 0;
    m_wrst     = 1'b0;
    m_pv       = 1'b0;
    m_ps       = 1'b0;
  endfunction

  function automatic void begin_round();
    m_in_round = 1'b1;
    m_frames   = 0;
    m_result   = 0;
    m_wrst     = 1'b1;
  endfunction

  function automatic void end_round(input int result);
    m_in_round = 1'b0;
    m_result   = result;
    m_hold     = 0;
  endfunction

  function automatic void model_step(input bit v, input bit s, input bit c, input bit a);
    bit tick;
    bit rise;
    tick   = v && !m_pv;
    rise   = s && !m_ps;
    m_pv   = v;
    m_ps   = s;
    m_wrst = 1'b0;
    if (m_in_round) begin
      if (c)                                  end_round(1);
      else if (a)                             end_round(2);
      else if (tick && m_frames >= ROUND_SEC * FPS) end_round(2);
      else if (tick)                          m_frames++;
    end else if (m_result != 0) begin
      if (m_hold < HOLD_FRAMES) begin
        if (tick) m_hold++;
      end else if (rise) begin
        begin_round();
      end
    end else if (rise) begin
      begin_round();
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.go      = 2'(m_result);
    e.playing = m_in_round;
    e.freeze  = !m_in_round;
    e.wrst    = m_wrst;
    e.sec     = 8'(ROUND_SEC - m_frames / FPS);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit s, input bit c, input bit a);
    @(negedge clk);
    vblnk      = v;
    start      = s;
    caught     = c;
    all_cheese = a;
    model_step(v, s, c, a);
    exp_q.push_back(model_out());
  endtask

  task automatic tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_pulse();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset mid-cycle; outputs must reach idle values without a clock edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_gameover", int'(gameover), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_freeze", int'(freeze), 1);
    chk("rst_world_rst", int'(world_rst), 0);
    chk("rst_sec_left", int'(sec_left), ROUND_SEC);
    model_reset();
    exp_q.delete();
    vblnk      = 1'b0;
    start      = 1'b0;
    caught     = 1'b0;
    all_cheese = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compares every registered output update against the scoreboard.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {gameover, playing, freeze, world_rst, sec_left};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL outputs t=%0t actual go=%b play=%b frz=%b wrst=%b sec=%0d expected go=%b play=%b frz=%b wrst=%b sec=%0d",
                   $time, act.go, act.playing, act.freeze, act.wrst, act.sec,
                   e.go, e.playing, e.freeze, e.wrst, e.sec);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    apply_reset();

    // Events while idle change nothing.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Start, then a full timed-out round.
    start_pulse();
    repeat (ROUND_SEC * FPS + 1) tick();

    // Start during hold is ignored; after the hold a start begins a new round.
    start_pulse();
    repeat (2) tick();
    start_pulse();
    repeat (HOLD_FRAMES - 2) tick();
    start_pulse();

    // caught and all_cheese together: Tom wins.
    repeat (2) tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (HOLD_FRAMES) tick();
    start_pulse();

    // all_cheese alone: Jerry wins.
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (HOLD_FRAMES) tick();
    start_pulse();

    // Reset mid-round with two seconds left.
    repeat (FPS) tick();
    apply_reset();

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 249) == 0));
      if (i % 1000 == 999) apply_reset();
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
